hdmi_island_sequencer: RTL and testbench
========================================

// Module: hdmi_island_sequencer
// PURPOSE
//  Upstream neighbour of the per-channel TMDS encoders. On a start pulse from the
//  timing generator it runs one HDMI data island: preamble, leading guard band, then
//  1..MAX_PACKETS 32-cycle packets with serial BCH ECC, then trailing guard band.
//  Drives mode/control/TERC4 nibbles for channels 0-2. The top level muxes these
//  outputs with the video path while busy=1.
// PARAMETERS
//  MAX_PACKETS   2   max contiguous packets per island (1..18)
//  PREAMBLE_LEN  8   control-period preamble cycles before the leading guard band
// PORTS
//  clk_pixel   in   1    pixel clock
//  reset_n     in   1    asynchronous reset, active low
//  start       in   1    1-cycle pulse: begin island (ignored while busy)
//  hsync       in   1    HSYNC, carried on ch0 bit0 / ctl0[0]
//  vsync       in   1    VSYNC, carried on ch0 bit1 / ctl0[1]
//  pkt_valid   in   1    packet available
//  pkt_ready   out  1    1-cycle pulse: packet consumed this cycle
//  pkt_header  in   24   header bytes HB0..HB2, LSB first
//  pkt_body    in   224  subpacket k = pkt_body[56k+55:56k], k=0..3, LSB first
//  busy        out  1    island in progress (preamble through trailing guard)
//  mode        out  3    0=control, 2=video guard (unused here), 3=island, 4=island guard
//  ctl0        out  2    {vsync,hsync}
//  ctl1        out  2    {CTL1,CTL0}
//  ctl2        out  2    {CTL3,CTL2}
//  di0/di1/di2 out  4    TERC4 nibble, channels 0/1/2
// BEHAVIOUR
//  - All outputs registered. Reset: busy=0, pkt_ready=0, mode=0, ctl0/1/2=0, di*=0,
//    FSM=IDLE, ECC regs=0. Reset mid-island aborts immediately; no partial packet is
//    resumed.
//  - ctl0 = {vsync,hsync} registered every cycle, so it has 1-cycle latency.
//  - FSM: IDLE -> PRE -> LGB -> PKT -> TGB -> IDLE.
//  - IDLE: mode=0, ctl1=ctl2=0. start at cycle T -> PRE; busy=1 from T+1.
//  - PRE (PREAMBLE_LEN cycles): mode=0, ctl1=2'b01, ctl2=2'b01.
//  - LGB (2 cycles): mode=4, ctl1=ctl2=0.
//    Latch the packet on the last LGB cycle: if pkt_valid, load header/body and pulse
//    pkt_ready; else load a null packet (all zeros) with no pkt_ready.
//  - PKT (32 cycles, idx 0..31): mode=3.
//    di0 = {idx!=0 || pkt_no!=0 ? 1'b1 : 1'b0, hdr_bit, vsync, hsync}.
//  - Header bits: hdr_bit = header[idx] for idx<24, else ecc_h[idx-24].
//  - Subpacket k bits: di1[k] = sp_k bit 2*idx, di2[k] = sp_k bit 2*idx+1.
//    Source is body bits for idx<28, else ecc_k bits 2*(idx-28) and 2*(idx-28)+1.
//  - BCH: g(x)=x^8+x^7+x^6+1, LSB-first serial.
//    Update: ecc <= {1'b0,ecc[7:1]} ^ ((ecc[0]^b) ? 8'h83 : 8'h00).
//    Header ECC: 1 bit/cycle over idx 0..23.
//    Subpacket ECC: 2 bits/cycle (two chained steps) over idx 0..27.
//    ECC regs clear at each packet latch.
//  - Continuation: at idx=31, if pkt_valid and pkt_no+1<MAX_PACKETS, latch the next
//    packet (pkt_ready pulse), pkt_no++, and stay in PKT. Otherwise go to TGB.
//    No null packets are inserted after the first packet.
//  - TGB (2 cycles): mode=4. Then IDLE with busy=0 on the following cycle.
//  - Island length = PREAMBLE_LEN + 2 + 32*N + 2 cycles, N = packets sent.
//  - start while busy: ignored. start and pkt_valid in the same cycle: pkt_valid is
//    only sampled at latch points.
//  - pkt_header/pkt_body must stay stable while pkt_valid=1 until pkt_ready.
// STRUCTURE
//  - Shared include hdmi_defs.vh holds:
//    - MODE_CONTROL/VIDEO/VGUARD/ISLAND/IGUARD
//    - ISLAND_PREAMBLE = 4'b0101
//    - BCH_POLY = 8'h83
//    - FSM state encodings
//  - Sub-module hdmi_bch_ecc (parameter BITS_PER_CLK = 1 or 2; ports clr, en,
//    din[BITS-1:0], ecc[7:0]). Five instances: 1 header + 4 subpackets.
//  - Top level holds the FSM, idx/pkt_no counters, packet shift registers and output
//    registers.
// TESTING
//  - Null island: start, pkt_valid=0, hsync=1, vsync=0.
//    -> 8 PRE cycles with ctl1=ctl2=01; 2 mode=4 cycles; 32 mode=3 cycles with
//       di0=0001 then 1001 and di1=di2=0; 2 mode=4 cycles; busy high for exactly 44
//       cycles; no pkt_ready pulse.
//  - AVI header 24'h0D0282, body from a reference vector.
//    -> ch0 bit2 stream and di1/di2 bits match the software BCH model bit-for-bit;
//       pkt_ready pulses once.
//  - MAX_PACKETS=2, pkt_valid held high.
//    -> two back-to-back 32-cycle packets; di0[3]=1 on idx0 of packet 2;
//       pkt_ready pulses twice; island length 76 cycles.
//  - start pulses at cycles 3, 10 and 40 of an island.
//    -> ignored; exactly one island. A start one cycle after busy falls is accepted.
//  - reset_n low during PKT idx 15.
//    -> outputs 0 immediately (async); after release, start gives a clean new island
//       with fresh ECC.
//  - hsync/vsync toggled every cycle.
//    -> ctl0 and di0[1:0] track them with exactly 1-cycle latency in every state.

Source files
------------

// File: rtl/hdmi_island_sequencer_pkg.sv
// Shared definitions for the HDMI data island sequencer: TMDS mode codes,
// the island preamble pattern, the BCH polynomial and the sequencer states.
package hdmi_island_sequencer_pkg;

  localparam logic [2:0] MODE_CONTROL = 3'd0;
  localparam logic [2:0] MODE_VIDEO   = 3'd1;
  localparam logic [2:0] MODE_VGUARD  = 3'd2;
  localparam logic [2:0] MODE_ISLAND  = 3'd3;
  localparam logic [2:0] MODE_IGUARD  = 3'd4;

  // {CTL3,CTL2,CTL1,CTL0} during the data island preamble
  localparam logic [3:0] ISLAND_PREAMBLE = 4'b0101;

  localparam logic [7:0] BCH_POLY = 8'h83;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_LGB,
    ST_PKT,
    ST_TGB
  } state_t;

  // One LSB-first step of the g(x)=x^8+x^7+x^6+1 ECC shift register
  function automatic logic [7:0] bch_step(input logic [7:0] ecc, input logic b);
    return {1'b0, ecc[7:1]} ^ ((ecc[0] ^ b) ? BCH_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/hdmi_bch_ecc.sv
// Serial BCH ECC accumulator consuming BITS_PER_CLK bits per pixel clock,
// lowest bit first. A clear together with an enable restarts from zero.
module hdmi_bch_ecc #(
  parameter int BITS_PER_CLK = 1
) (
  input  logic                    clk_pixel,
  input  logic                    reset_n,
  input  logic                    clr,
  input  logic                    en,
  input  logic [BITS_PER_CLK-1:0] din,
  output logic [7:0]              ecc
);
  import hdmi_island_sequencer_pkg::*;

  logic [7:0] ecc_next;

  always_comb begin
    ecc_next = clr ? 8'h00 : ecc;
    if (en) begin
      for (int i = 0; i < BITS_PER_CLK; i++) begin
        ecc_next = bch_step(ecc_next, din[i]);
      end
    end
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      ecc <= 8'h00;
    end else begin
      ecc <= ecc_next;
    end
  end

endmodule

// File: rtl/hdmi_island_sequencer.sv
// Runs one HDMI data island (preamble, guard bands, 1..MAX_PACKETS packets with
// serial BCH ECC) and drives registered mode/control/TERC4 nibbles for ch0-2.
module hdmi_island_sequencer #(
  parameter int MAX_PACKETS  = 2,
  parameter int PREAMBLE_LEN = 8
) (
  input  logic         clk_pixel,
  input  logic         reset_n,
  input  logic         start,
  input  logic         hsync,
  input  logic         vsync,
  input  logic         pkt_valid,
  output logic         pkt_ready,
  input  logic [23:0]  pkt_header,
  input  logic [223:0] pkt_body,
  output logic         busy,
  output logic [2:0]   mode,
  output logic [1:0]   ctl0,
  output logic [1:0]   ctl1,
  output logic [1:0]   ctl2,
  output logic [3:0]   di0,
  output logic [3:0]   di1,
  output logic [3:0]   di2
);
  import hdmi_island_sequencer_pkg::*;

  state_t       state, state_n;
  logic [7:0]   cnt, cnt_n;
  logic [4:0]   pkt_no, pkt_no_n;
  logic [23:0]  hdr_q, hdr_src;
  logic [223:0] body_q, body_src;
  logic         latch, take;

  logic [4:0]   idx;
  logic         in_pkt, hdr_bit;
  logic [55:0]  sp_word [4];
  logic [1:0]   sp_bits [4];
  logic [7:0]   ecc_h;
  logic [7:0]   ecc_sp [4];

  logic         busy_n, pkt_ready_n;
  logic [2:0]   mode_n;
  logic [1:0]   ctl1_n, ctl2_n;
  logic [3:0]   di0_n, di1_n, di2_n;

  // Sequencing: cnt counts cycles within a phase and doubles as the packet bit index
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    pkt_no_n = pkt_no;
    latch    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_n = ST_PRE;
          cnt_n   = 8'd0;
        end
      end
      ST_PRE: begin
        if (cnt == 8'(PREAMBLE_LEN - 1)) begin
          state_n = ST_LGB;
          cnt_n   = 8'd0;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      ST_LGB: begin
        if (cnt == 8'd1) begin
          state_n  = ST_PKT;
          cnt_n    = 8'd0;
          pkt_no_n = 5'd0;
          latch    = 1'b1;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      ST_PKT: begin
        if (cnt == 8'd31) begin
          cnt_n = 8'd0;
          if (pkt_valid && (int'(pkt_no) + 1 < MAX_PACKETS)) begin
            pkt_no_n = pkt_no + 5'd1;
            latch    = 1'b1;
          end else begin
            state_n = ST_TGB;
          end
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      ST_TGB: begin
        if (cnt == 8'd1) begin
          state_n = ST_IDLE;
          cnt_n   = 8'd0;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = 8'd0;
      end
    endcase
  end

  // A latch without pkt_valid (only possible at the first packet) sends a null packet
  assign take     = latch && pkt_valid;
  assign hdr_src  = latch ? (take ? pkt_header : 24'h0) : hdr_q;
  assign body_src = latch ? (take ? pkt_body : 224'h0) : body_q;
  assign idx      = cnt_n[4:0];
  assign in_pkt   = (state_n == ST_PKT);

  // Outputs are built from next-cycle state so registering them adds no lag
  always_comb begin
    hdr_bit = (idx < 5'd24) ? hdr_src[idx] : ecc_h[idx[2:0]];
    for (int k = 0; k < 4; k++) begin
      sp_word[k] = body_src[k*56 +: 56];
      if (idx < 5'd28) begin
        sp_bits[k] = {sp_word[k][{idx, 1'b1}], sp_word[k][{idx, 1'b0}]};
      end else begin
        sp_bits[k] = {ecc_sp[k][{idx[1:0], 1'b1}], ecc_sp[k][{idx[1:0], 1'b0}]};
      end
    end

    busy_n      = (state_n != ST_IDLE);
    pkt_ready_n = take;
    mode_n      = MODE_CONTROL;
    ctl1_n      = 2'b00;
    ctl2_n      = 2'b00;
    di0_n       = {2'b00, vsync, hsync};
    di1_n       = 4'h0;
    di2_n       = 4'h0;
    case (state_n)
      ST_PRE: begin
        ctl1_n = ISLAND_PREAMBLE[1:0];
        ctl2_n = ISLAND_PREAMBLE[3:2];
      end
      ST_LGB, ST_TGB: mode_n = MODE_IGUARD;
      ST_PKT: begin
        mode_n   = MODE_ISLAND;
        di0_n[3] = (idx != 5'd0) || (pkt_no_n != 5'd0);
        di0_n[2] = hdr_bit;
        for (int k = 0; k < 4; k++) begin
          di1_n[k] = sp_bits[k][0];
          di2_n[k] = sp_bits[k][1];
        end
      end
      default: mode_n = MODE_CONTROL;
    endcase
  end

  hdmi_bch_ecc #(.BITS_PER_CLK(1)) u_ecc_hdr (
    .clk_pixel (clk_pixel),
    .reset_n   (reset_n),
    .clr       (latch),
    .en        (in_pkt && (idx < 5'd24)),
    .din       (hdr_bit),
    .ecc       (ecc_h)
  );

  for (genvar g = 0; g < 4; g++) begin : g_sp_ecc
    hdmi_bch_ecc #(.BITS_PER_CLK(2)) u_ecc_sp (
      .clk_pixel (clk_pixel),
      .reset_n   (reset_n),
      .clr       (latch),
      .en        (in_pkt && (idx < 5'd28)),
      .din       (sp_bits[g]),
      .ecc       (ecc_sp[g])
    );
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      cnt       <= 8'd0;
      pkt_no    <= 5'd0;
      hdr_q     <= 24'h0;
      body_q    <= 224'h0;
      busy      <= 1'b0;
      pkt_ready <= 1'b0;
      mode      <= MODE_CONTROL;
      ctl0      <= 2'b00;
      ctl1      <= 2'b00;
      ctl2      <= 2'b00;
      di0       <= 4'h0;
      di1       <= 4'h0;
      di2       <= 4'h0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      pkt_no    <= pkt_no_n;
      hdr_q     <= hdr_src;
      body_q    <= body_src;
      busy      <= busy_n;
      pkt_ready <= pkt_ready_n;
      mode      <= mode_n;
      ctl0      <= {vsync, hsync};
      ctl1      <= ctl1_n;
      ctl2      <= ctl2_n;
      di0       <= di0_n;
      di1       <= di1_n;
      di2       <= di2_n;
    end
  end

endmodule

// File: tb/tb_hdmi_island_sequencer.sv
// Scoreboard bench: each driven cycle pushes the expected output frame built from a
// packet-level island model with software BCH; the frame is popped one clock later.
module tb_hdmi_island_sequencer;
  localparam int MAX_PACKETS  = 2;
  localparam int PREAMBLE_LEN = 8;

  typedef struct packed {
    logic       busy;
    logic       pkt_ready;
    logic [2:0] mode;
    logic [1:0] ctl0;
    logic [1:0] ctl1;
    logic [1:0] ctl2;
    logic [3:0] di0;
    logic [3:0] di1;
    logic [3:0] di2;
  } frame_t;

  logic         clk_pixel = 1'b0;
  logic         reset_n   = 1'b1;
  logic         start     = 1'b0;
  logic         hsync     = 1'b0;
  logic         vsync     = 1'b0;
  logic         pkt_valid = 1'b0;
  logic         pkt_ready;
  logic [23:0]  pkt_header = '0;
  logic [223:0] pkt_body   = '0;
  logic         busy;
  logic [2:0]   mode;
  logic [1:0]   ctl0, ctl1, ctl2;
  logic [3:0]   di0, di1, di2;

  frame_t island_q[$];
  frame_t sb_q[$];
  int     n_cmp = 0;
  int     n_err = 0;
  int     avail = 0;
  logic   model_busy = 1'b0;

  hdmi_island_sequencer #(
    .MAX_PACKETS  (MAX_PACKETS),
    .PREAMBLE_LEN (PREAMBLE_LEN)
  ) dut (
    .clk_pixel  (clk_pixel),
    .reset_n    (reset_n),
    .start      (start),
    .hsync      (hsync),
    .vsync      (vsync),
    .pkt_valid  (pkt_valid),
    .pkt_ready  (pkt_ready),
    .pkt_header (pkt_header),
    .pkt_body   (pkt_body),
    .busy       (busy),
    .mode       (mode),
    .ctl0       (ctl0),
    .ctl1       (ctl1),
    .ctl2       (ctl2),
    .di0        (di0),
    .di1        (di1),
    .di2        (di2)
  );

  always #5 clk_pixel = ~clk_pixel;

  function automatic logic [7:0] bch(input logic [7:0] e, input logic b);
    return {1'b0, e[7:1]} ^ ((e[0] ^ b) ? 8'h83 : 8'h00);
  endfunction

  function automatic frame_t observed();
    frame_t o;
    o.busy = busy; o.pkt_ready = pkt_ready; o.mode = mode;
    o.ctl0 = ctl0; o.ctl1 = ctl1; o.ctl2 = ctl2;
    o.di0 = di0; o.di1 = di1; o.di2 = di2;
    return o;
  endfunction

  task automatic checkOutput(input string tag, input frame_t obs, input frame_t exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("[TB] FAIL %s @%0t: got %h expected %h", tag, $time, obs, exp);
    end
  endtask

  // Expected island frames (ctl0 and di0[1:0] are overlaid per cycle)
  task automatic buildIsland();
    frame_t       f;
    logic [7:0]   e;
    logic [23:0]  hdr;
    logic [223:0] bdy;
    logic [55:0]  sp;
    logic [31:0]  hw;
    logic [63:0]  spw [4];
    logic         has_pkt;
    int           n;
    has_pkt = (avail > 0);
    n   = has_pkt ? ((avail < MAX_PACKETS) ? avail : MAX_PACKETS) : 1;
    hdr = has_pkt ? pkt_header : 24'h0;
    bdy = has_pkt ? pkt_body : 224'h0;
    e = 8'h00;
    for (int i = 0; i < 24; i++) e = bch(e, hdr[i]);
    hw = {e, hdr};
    for (int k = 0; k < 4; k++) begin
      sp = bdy[k*56 +: 56];
      e  = 8'h00;
      for (int i = 0; i < 56; i++) e = bch(e, sp[i]);
      spw[k] = {e, sp};
    end
    f = '0; f.busy = 1'b1; f.ctl1 = 2'b01; f.ctl2 = 2'b01;
    repeat (PREAMBLE_LEN) island_q.push_back(f);
    f = '0; f.busy = 1'b1; f.mode = 3'd4;
    repeat (2) island_q.push_back(f);
    for (int p = 0; p < n; p++) begin
      for (int i = 0; i < 32; i++) begin
        f = '0; f.busy = 1'b1; f.mode = 3'd3;
        f.pkt_ready = has_pkt && (i == 0);
        f.di0[3] = (i != 0) || (p != 0);
        f.di0[2] = hw[i];
        for (int k = 0; k < 4; k++) begin
          f.di1[k] = spw[k][2*i];
          f.di2[k] = spw[k][2*i+1];
        end
        island_q.push_back(f);
      end
    end
    f = '0; f.busy = 1'b1; f.mode = 3'd4;
    repeat (2) island_q.push_back(f);
  endtask

  // Drive one cycle, push its expected result, then compare one clock later
  task automatic applyStimulus(input logic st, input logic h, input logic v, input string tag);
    frame_t f;
    frame_t e;
    start = st; hsync = h; vsync = v; pkt_valid = (avail > 0);
    if (st && !model_busy) buildIsland();
    f = (island_q.size() > 0) ? island_q.pop_front() : frame_t'('0);
    f.ctl0 = {v, h};
    f.di0[1:0] = {v, h};
    model_busy = f.busy;
    sb_q.push_back(f);
    @(posedge clk_pixel); #1;
    start = 1'b0;
    e = sb_q.pop_front();
    checkOutput(tag, observed(), e);
    if (pkt_ready && avail > 0) avail--;
  endtask

  initial begin
    #3 reset_n = 1'b0;
    #2 checkOutput("reset", observed(), frame_t'('0));
    repeat (2) @(posedge clk_pixel);
    #1 reset_n = 1'b1;

    repeat (3) applyStimulus(1'b0, 1'b1, 1'b0, "idle");

    // Null island
    avail = 0;
    applyStimulus(1'b1, 1'b1, 1'b0, "null");
    repeat (48) applyStimulus(1'b0, 1'b1, 1'b0, "null");

    // AVI packet with hsync/vsync toggling every cycle
    pkt_header = 24'h0D0282;
    pkt_body   = {56'h0, 56'h0, 56'h00000000000004, 56'h00000000281847};
    avail = 1;
    for (int c = 0; c < 52; c++) applyStimulus(c == 0, c[0], ~c[0], "avi");

    // pkt_valid held high: two back-to-back packets
    pkt_header = 24'h0A0184;
    pkt_body   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    avail = 100;
    for (int c = 0; c < 82; c++) applyStimulus(c == 0, 1'b0, 1'b1, "max2");
    avail = 0;

    // Starts while busy are ignored; one right after busy falls is taken
    for (int c = 0; c < 96; c++)
      applyStimulus(c == 0 || c == 3 || c == 10 || c == 40 || c == 45, c[1], c[2], "ignore");

    // Async reset during PKT idx 15, then a clean island
    avail = 100;
    for (int c = 0; c < 26; c++) applyStimulus(c == 0, 1'b1, 1'b1, "pre_rst");
    reset_n = 1'b0;
    #1 checkOutput("async_rst", observed(), frame_t'('0));
    island_q.delete();
    sb_q.delete();
    model_busy = 1'b0;
    repeat (2) begin
      @(posedge clk_pixel); #1;
      checkOutput("in_rst", observed(), frame_t'('0));
    end
    reset_n = 1'b1;
    pkt_header = 24'($urandom);
    pkt_body   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    avail = 1;
    for (int c = 0; c < 50; c++) applyStimulus(c == 0, 1'($urandom), 1'($urandom), "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
